// File: rtl/divisor_secuencial_if.sv
// rtl/divisor_secuencial_if.sv - operand/result bundle for the sequential divider
//   master: drives dividendo/validoA, divisor/validoB; observes ocupado,
//           cociente, residuo, divisionLista, divCero
//   slave : the divider side of the same signals
interface divisor_secuencial_if #(
  parameter int ANCHO = 16
);
  logic [ANCHO-1:0] dividendo;
  logic             validoA;
  logic [ANCHO-1:0] divisor;
  logic             validoB;
  logic             ocupado;
  logic [ANCHO-1:0] cociente;
  logic [ANCHO-1:0] residuo;
  logic             divisionLista;
  logic             divCero;

  modport master (
    output dividendo, validoA, divisor, validoB,
    input  ocupado, cociente, residuo, divisionLista, divCero
  );

  modport slave (
    input  dividendo, validoA, divisor, validoB,
    output ocupado, cociente, residuo, divisionLista, divCero
  );
endinterface

// File: rtl/divisor_secuencial.sv
// rtl/divisor_secuencial.sv - restoring unsigned divider, one quotient bit per clock
//   clock   : rising-edge system clock
//   reset_n : synchronous active-low reset
//   bus     : slave side of divisor_secuencial_if
//             in : dividendo/validoA, divisor/validoB (independent level strobes)
//             out: ocupado (iterating), cociente/residuo (registered result),
//                  divisionLista (result held), divCero (divisor was zero)
module divisor_secuencial #(
  parameter int ANCHO = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  divisor_secuencial_if.slave  bus
);

  localparam int CW = $clog2(ANCHO + 1);
  localparam logic [CW-1:0] CNT_INI = CW'(ANCHO);
  localparam logic [CW-1:0] CNT_UNO = CW'(1);

  typedef enum logic [1:0] {
    ESPERA  = 2'd0,
    CALCULO = 2'd1,
    LISTO   = 2'd2
  } estado_t;

  estado_t          estado_q,   estado_d;
  logic [ANCHO-1:0] a_q,        a_d;
  logic [ANCHO-1:0] b_q,        b_d;
  logic             have_a_q,   have_a_d;
  logic             have_b_q,   have_b_d;
  logic [ANCHO-1:0] r_q,        r_d;
  logic [ANCHO-1:0] q_q,        q_d;
  logic [CW-1:0]    cnt_q,      cnt_d;
  logic [ANCHO-1:0] cociente_q, cociente_d;
  logic [ANCHO-1:0] residuo_q,  residuo_d;
  logic             lista_q,    lista_d;
  logic             cero_q,     cero_d;

  // Trial remainder: previous partial remainder with the next dividend bit
  // shifted in. One extra bit so the compare sees the full shifted value.
  logic [ANCHO:0]   trial;
  logic             resta;

  always_comb begin
    trial = {r_q, q_q[ANCHO-1]};
    resta = (trial >= {1'b0, b_q});
  end

  always_comb begin
    estado_d   = estado_q;
    a_d        = a_q;
    b_d        = b_q;
    have_a_d   = have_a_q;
    have_b_d   = have_b_q;
    r_d        = r_q;
    q_d        = q_q;
    cnt_d      = cnt_q;
    cociente_d = cociente_q;
    residuo_d  = residuo_q;
    lista_d    = lista_q;
    cero_d     = cero_q;

    case (estado_q)
      ESPERA, LISTO: begin
        if (bus.validoA) begin
          a_d      = bus.dividendo;
          have_a_d = 1'b1;
        end
        if (bus.validoB) begin
          b_d      = bus.divisor;
          have_b_d = 1'b1;
        end
        // Any capture while a result is held retires that result.
        if ((estado_q == LISTO) && (bus.validoA || bus.validoB)) begin
          lista_d  = 1'b0;
          cero_d   = 1'b0;
          estado_d = ESPERA;
        end
        if (have_a_d && have_b_d) begin
          estado_d = CALCULO;
          have_a_d = 1'b0;
          have_b_d = 1'b0;
          cnt_d    = CNT_INI;
          r_d      = '0;
          q_d      = a_d;
        end
      end

      CALCULO: begin
        if (b_q == '0) begin
          // Divide by zero completes on the first CALCULO edge.
          cociente_d = '1;
          residuo_d  = a_q;
          cero_d     = 1'b1;
          lista_d    = 1'b1;
          estado_d   = LISTO;
        end else begin
          // When resta is set the difference is below b_q, so the low
          // ANCHO bits of the subtraction are exact.
          r_d   = resta ? (trial[ANCHO-1:0] - b_q) : trial[ANCHO-1:0];
          q_d   = {q_q[ANCHO-2:0], resta};
          cnt_d = cnt_q - CNT_UNO;
          if (cnt_q == CNT_UNO) begin
            cociente_d = q_d;
            residuo_d  = r_d;
            lista_d    = 1'b1;
            estado_d   = LISTO;
          end
        end
      end

      default: begin
        estado_d = ESPERA;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      estado_q   <= ESPERA;
      a_q        <= '0;
      b_q        <= '0;
      have_a_q   <= 1'b0;
      have_b_q   <= 1'b0;
      r_q        <= '0;
      q_q        <= '0;
      cnt_q      <= '0;
      cociente_q <= '0;
      residuo_q  <= '0;
      lista_q    <= 1'b0;
      cero_q     <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      a_q        <= a_d;
      b_q        <= b_d;
      have_a_q   <= have_a_d;
      have_b_q   <= have_b_d;
      r_q        <= r_d;
      q_q        <= q_d;
      cnt_q      <= cnt_d;
      cociente_q <= cociente_d;
      residuo_q  <= residuo_d;
      lista_q    <= lista_d;
      cero_q     <= cero_d;
    end
  end

  assign bus.ocupado       = (estado_q == CALCULO);
  assign bus.cociente      = cociente_q;
  assign bus.residuo       = residuo_q;
  assign bus.divisionLista = lista_q;
  assign bus.divCero       = cero_q;

endmodule

// File: tb/tb_divisor_secuencial.sv
// tb/tb_divisor_secuencial.sv - self-checking bench for divisor_secuencial
module tb_divisor_secuencial;

  localparam int ANCHO = 16;

  logic clock;
  logic reset_n;
  int   checks;
  int   failures;

  divisor_secuencial_if #(.ANCHO(ANCHO)) bus ();

  divisor_secuencial #(.ANCHO(ANCHO)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d (0x%0h) exp=%0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference: plain arithmetic with the divide-by-zero convention.
  function automatic logic [ANCHO-1:0] ref_q(input logic [ANCHO-1:0] a, input logic [ANCHO-1:0] b);
    return (b == 0) ? {ANCHO{1'b1}} : a / b;
  endfunction

  function automatic logic [ANCHO-1:0] ref_r(input logic [ANCHO-1:0] a, input logic [ANCHO-1:0] b);
    return (b == 0) ? a : a % b;
  endfunction

  // Waits from just after the start edge until the result appears,
  // checking latency, busy duration and the result.
  task automatic wait_result(input string tag, input logic [ANCHO-1:0] a, input logic [ANCHO-1:0] b);
    int lat;
    int ocup;
    lat  = 0;
    ocup = 0;
    chk({tag, ".lista_drop"}, 32'(bus.divisionLista), 32'd0);
    while (!bus.divisionLista && lat < 40) begin
      if (bus.ocupado) ocup++;
      tick();
      lat++;
    end
    chk({tag, ".latencia"}, 32'(lat), (b == 0) ? 32'd1 : 32'(ANCHO));
    chk({tag, ".ocupado"},  32'(ocup), (b == 0) ? 32'd1 : 32'(ANCHO));
    chk({tag, ".cociente"}, 32'(bus.cociente), 32'(ref_q(a, b)));
    chk({tag, ".residuo"},  32'(bus.residuo),  32'(ref_r(a, b)));
    chk({tag, ".divCero"},  32'(bus.divCero),  32'(b == 0));
    chk({tag, ".ocup_fin"}, 32'(bus.ocupado),  32'd0);
  endtask

  task automatic start_both(input logic [ANCHO-1:0] a, input logic [ANCHO-1:0] b);
    bus.dividendo = a;
    bus.divisor   = b;
    bus.validoA   = 1'b1;
    bus.validoB   = 1'b1;
    tick();
    bus.validoA   = 1'b0;
    bus.validoB   = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [ANCHO-1:0] a, input logic [ANCHO-1:0] b);
    start_both(a, b);
    wait_result(tag, a, b);
  endtask

  initial begin
    logic [ANCHO-1:0] ra;
    logic [ANCHO-1:0] rb;
    checks        = 0;
    failures      = 0;
    reset_n       = 1'b0;
    bus.dividendo = '0;
    bus.divisor   = '0;
    bus.validoA   = 1'b0;
    bus.validoB   = 1'b0;
    tick();
    tick();
    chk("rst.cociente", 32'(bus.cociente),      32'd0);
    chk("rst.residuo",  32'(bus.residuo),       32'd0);
    chk("rst.lista",    32'(bus.divisionLista), 32'd0);
    chk("rst.cero",     32'(bus.divCero),       32'd0);
    chk("rst.ocupado",  32'(bus.ocupado),       32'd0);
    reset_n = 1'b1;
    tick();

    // Basic, then result must hold stable.
    run_op("basic", 16'd100, 16'd7);
    tick();
    tick();
    tick();
    chk("basic.hold_q",     32'(bus.cociente),      32'd14);
    chk("basic.hold_lista", 32'(bus.divisionLista), 32'd1);

    run_op("max_div1", 16'hFFFF, 16'd1);
    run_op("small",    16'd5,    16'd9);

    // Split arrival: dividend at cycle 0, divisor at cycle 4.
    bus.dividendo = 16'd1000;
    bus.validoA   = 1'b1;
    tick();
    bus.validoA   = 1'b0;
    chk("split.lista_drop", 32'(bus.divisionLista), 32'd0);
    tick();
    tick();
    tick();
    chk("split.idle", 32'(bus.ocupado), 32'd0);
    bus.divisor = 16'd10;
    bus.validoB = 1'b1;
    tick();
    bus.validoB = 1'b0;
    wait_result("split", 16'd1000, 16'd10);

    run_op("divcero", 16'd1234, 16'd0);

    // Busy ignore: strobes during CALCULO must not alter anything.
    start_both(16'd100, 16'd7);
    tick();
    tick();
    bus.dividendo = 16'd50;
    bus.validoA   = 1'b1;
    tick();
    bus.validoA   = 1'b0;
    tick();
    bus.divisor   = 16'd5;
    bus.validoB   = 1'b1;
    tick();
    bus.validoB   = 1'b0;
    begin
      int n;
      n = 0;
      while (!bus.divisionLista && n < 40) begin
        tick();
        n++;
      end
      chk("busy.lat_rest", 32'(n), 32'(ANCHO - 5));
    end
    chk("busy.cociente", 32'(bus.cociente), 32'd14);
    chk("busy.residuo",  32'(bus.residuo),  32'd2);
    tick();
    tick();
    chk("busy.no_new_op", 32'(bus.ocupado),       32'd0);
    chk("busy.lista",     32'(bus.divisionLista), 32'd1);

    // Reset mid-operation, then a clean operation.
    start_both(16'd100, 16'd7);
    for (int i = 0; i < 7; i++) tick();
    chk("rstmid.ocupado_pre", 32'(bus.ocupado), 32'd1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("rstmid.cociente", 32'(bus.cociente),      32'd0);
    chk("rstmid.residuo",  32'(bus.residuo),       32'd0);
    chk("rstmid.lista",    32'(bus.divisionLista), 32'd0);
    chk("rstmid.ocupado",  32'(bus.ocupado),       32'd0);
    tick();
    chk("rstmid.discard", 32'(bus.ocupado), 32'd0);
    run_op("post_rst", 16'd81, 16'd9);

    // Back-to-back: new pair on the first LISTO cycle.
    run_op("b2b_1", 16'd100, 16'd7);
    run_op("b2b_2", 16'd200, 16'd3);

    // Randomized operations with random idle gaps.
    for (int k = 0; k < 30; k++) begin
      ra = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = '0;
        1:       rb = 16'($urandom_range(1, 15));
        default: rb = 16'($urandom);
      endcase
      for (int g = $urandom_range(0, 2); g > 0; g--) tick();
      run_op($sformatf("rnd%0d", k), ra, rb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
